// File: rtl/clk_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_meter_pkg
// Purpose  : Shared state encoding and constants for the clock period meter.
// Revision : 1.0 - initial release
// ============================================================================
package clk_meter_pkg;

    // Narrower counters cannot represent a useful saturation window.
    localparam int CNT_W_MIN = 4;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meter_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_rise_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_rise_detect
// Purpose  : Two-flop synchronizer with a delayed copy for rising-edge detect.
// Revision : 1.0 - initial release
// ============================================================================
module sync_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic level,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s2_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1   <= sig_in;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign level = r_s2;
    assign rise  = r_s2 & ~r_s2_d;

endmodule
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : clk_period_meter
// Purpose  : Measures period and high time of a slow signal in clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic             w_level;
    logic             w_rise;

    meter_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_valid;
    logic             r_timeout;
    logic             r_locked;

    sync_rise_detect u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .level  (w_level),
        .rise   (w_rise)
    );

    // The rise cycle itself counts as cycle 1 of the new period, so both
    // counters reload to one rather than zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_cnt    <= C_CNT_ONE;
                        r_hcnt   <= C_CNT_ONE;
                        r_state  <= ST_MEASURE;
                        r_locked <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        r_period <= r_cnt;
                        r_high   <= r_hcnt;
                        r_valid  <= 1'b1;
                        r_cnt    <= C_CNT_ONE;
                        r_hcnt   <= C_CNT_ONE;
                    end else if (r_cnt == C_CNT_MAX) begin
                        // Saturated with no edge: give up and wait to re-arm.
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_locked  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                        if (w_level) begin
                            r_hcnt <= r_hcnt + C_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign period_out = r_period;
    assign high_out   = r_high;
    assign valid      = r_valid;
    assign timeout    = r_timeout;
    assign locked     = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_period_meter
// Purpose  : Self-checking bench; expected results come from rise spacing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        sig16 = 1'b0;
    logic        sig4  = 1'b0;
    logic [15:0] per16, hi16;
    logic [3:0]  per4, hi4;
    logic        v16, to16, lk16, v4, to4, lk4;

    bit          sel4 = 1'b0;
    bit          wave[$];
    logic [34:0] exp_tr[$];
    logic [34:0] obs_tr[$];
    logic [34:0] cur_tr;
    int          checks = 0;
    int          fails  = 0;

    clk_period_meter #(.CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .sig_in(sig16), .period_out(per16),
        .high_out(hi16), .valid(v16), .timeout(to16), .locked(lk16)
    );

    clk_period_meter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .sig_in(sig4), .period_out(per4),
        .high_out(hi4), .valid(v4), .timeout(to4), .locked(lk4)
    );

    always #5 clk = ~clk;

    assign cur_tr = sel4 ? {v4, to4, lk4, 12'd0, per4, 12'd0, hi4}
                         : {v16, to16, lk16, per16, hi16};

    task automatic add_phase(input bit lv, input int len);
        repeat (len) wave.push_back(lv);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; sig16 = 1'b0; sig4 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Entry k of a trace is the output state just after clk edge k, where
    // wave[k] is the level sampled at edge k. A rise sampled at k shows at k+2.
    task automatic model_wave(input int maxc);
        int n, n0, per, hi;
        bit armed, rise, prev, v, to;
        n = wave.size(); n0 = 0; per = 0; hi = 0; armed = 0; prev = 0;
        exp_tr.delete();
        exp_tr.push_back('0);
        exp_tr.push_back('0);
        for (int i = 0; i < n; i++) begin
            rise = wave[i] && !prev;
            prev = wave[i];
            v = 0; to = 0;
            if (!armed) begin
                if (rise) begin armed = 1; n0 = i; end
            end else if (rise) begin
                per = i - n0;
                hi = 0;
                for (int j = n0; j < i; j++) hi += int'(wave[j]);
                v = 1; n0 = i;
            end else if (i - n0 == maxc) begin
                to = 1; armed = 0;
            end
            exp_tr.push_back({v, to, armed, per[15:0], hi[15:0]});
        end
    endtask

    task automatic drive_wave();
        int n;
        bit lv;
        n = wave.size();
        obs_tr.delete();
        for (int t = 0; t < n + 2; t++) begin
            lv = wave[(t < n) ? t : n - 1];
            if (sel4) sig4 = lv; else sig16 = lv;
            @(posedge clk); #1;
            obs_tr.push_back(cur_tr);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [34:0] o, e;
        for (int i = 0; i < 10; i++) begin
            sig16 = ~sig16; sig4 = ~sig4;
            @(posedge clk); #1;
            checks++;
            if ({v16, to16, lk16, per16, hi16, v4, to4, lk4, per4, hi4} !== '0) begin
                fails++;
                $display("FAIL reset_hold cyc=%0d: got v=%b to=%b lk=%b per=%0d hi=%0d, expected all 0",
                         i, v16, to16, lk16, per16, hi16);
            end
            @(negedge clk);
        end
        sel4 = 0; sig16 = 0; sig4 = 0; rst = 1'b1;
        wave.delete(); add_phase(0, 2); add_phase(1, 4); add_phase(0, 4);
        model_wave(65535); drive_wave();
        foreach (obs_tr[t]) begin
            o = obs_tr[t]; e = exp_tr[t]; checks++;
            if (o !== e) begin fails++;
                $display("FAIL reset_arm t=%0d: got vtl=%b per=%0d hi=%0d, expected vtl=%b per=%0d hi=%0d",
                         t, o[34:32], o[31:16], o[15:0], e[34:32], e[31:16], e[15:0]); end
        end
    endtask

    task automatic test_square();
        logic [34:0] o, e;
        sel4 = 0; do_reset();
        wave.delete(); add_phase(0, 3);
        repeat (5) begin add_phase(1, 8); add_phase(0, 8); end
        add_phase(1, 2);
        model_wave(65535); drive_wave();
        foreach (obs_tr[t]) begin
            o = obs_tr[t]; e = exp_tr[t]; checks++;
            if (o !== e) begin fails++;
                $display("FAIL square t=%0d: got vtl=%b per=%0d hi=%0d, expected vtl=%b per=%0d hi=%0d",
                         t, o[34:32], o[31:16], o[15:0], e[34:32], e[31:16], e[15:0]); end
        end
    endtask

    task automatic test_duty();
        logic [34:0] o, e;
        sel4 = 0; do_reset();
        wave.delete(); add_phase(0, 2);
        repeat (4) begin add_phase(1, 3); add_phase(0, 13); end
        add_phase(1, 1);
        model_wave(65535); drive_wave();
        foreach (obs_tr[t]) begin
            o = obs_tr[t]; e = exp_tr[t]; checks++;
            if (o !== e) begin fails++;
                $display("FAIL duty t=%0d: got vtl=%b per=%0d hi=%0d, expected vtl=%b per=%0d hi=%0d",
                         t, o[34:32], o[31:16], o[15:0], e[34:32], e[31:16], e[15:0]); end
        end
    endtask

    task automatic test_timeout();
        logic [34:0] o, e;
        int nto, t_arm, t_to;
        sel4 = 1; do_reset();
        wave.delete(); add_phase(0, 2); add_phase(1, 25); add_phase(0, 3);
        add_phase(1, 3); add_phase(0, 3);
        model_wave(15); drive_wave();
        nto = 0; t_arm = -1; t_to = -1;
        foreach (obs_tr[t]) begin
            o = obs_tr[t]; e = exp_tr[t]; checks++;
            if (o[33]) begin nto++; if (t_to < 0) t_to = t; end
            if (o[32] && t_arm < 0) t_arm = t;
            if (o !== e) begin fails++;
                $display("FAIL timeout t=%0d: got vtl=%b per=%0d hi=%0d, expected vtl=%b per=%0d hi=%0d",
                         t, o[34:32], o[31:16], o[15:0], e[34:32], e[31:16], e[15:0]); end
        end
        checks++;
        if (nto != 1) begin fails++;
            $display("FAIL timeout_count: got %0d pulses, expected 1", nto); end
        checks++;
        if (t_to - t_arm != 15) begin fails++;
            $display("FAIL timeout_delay: got %0d cycles after arming, expected 15", t_to - t_arm); end
    endtask

    task automatic test_saturation();
        logic [34:0] o, e;
        int nv, nto;
        sel4 = 1; do_reset();
        wave.delete(); add_phase(0, 1);
        add_phase(1, 1); add_phase(0, 14);
        add_phase(1, 1); add_phase(0, 15);
        add_phase(1, 1); add_phase(0, 14);
        add_phase(1, 1); add_phase(0, 3);
        model_wave(15); drive_wave();
        nv = 0; nto = 0;
        foreach (obs_tr[t]) begin
            o = obs_tr[t]; e = exp_tr[t]; checks++;
            nv += int'(o[34]); nto += int'(o[33]);
            if (o !== e) begin fails++;
                $display("FAIL saturation t=%0d: got vtl=%b per=%0d hi=%0d, expected vtl=%b per=%0d hi=%0d",
                         t, o[34:32], o[31:16], o[15:0], e[34:32], e[31:16], e[15:0]); end
        end
        checks++;
        if (nv != 2 || nto != 1) begin fails++;
            $display("FAIL saturation_counts: got valid=%0d timeout=%0d, expected valid=2 timeout=1", nv, nto); end
    endtask

    task automatic test_random();
        logic [34:0] o, e;
        int lim;
        for (int r = 0; r < 6; r++) begin
            sel4 = r[0];
            lim = sel4 ? 9 : 20;
            do_reset();
            wave.delete(); add_phase(0, $urandom_range(5, 0));
            repeat (8) begin
                add_phase(1, $urandom_range(lim, 1));
                add_phase(0, $urandom_range(lim, 1));
            end
            add_phase(1, 1);
            model_wave(sel4 ? 15 : 65535); drive_wave();
            foreach (obs_tr[t]) begin
                o = obs_tr[t]; e = exp_tr[t]; checks++;
                if (o !== e) begin fails++;
                    $display("FAIL random%0d t=%0d: got vtl=%b per=%0d hi=%0d, expected vtl=%b per=%0d hi=%0d",
                             r, t, o[34:32], o[31:16], o[15:0], e[34:32], e[31:16], e[15:0]); end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [34:0] o, e;
        sel4 = 0; do_reset();
        wave.delete(); add_phase(0, 2);
        repeat (2) begin add_phase(1, 6); add_phase(0, 6); end
        add_phase(1, 5);
        model_wave(65535); drive_wave();
        foreach (obs_tr[t]) begin
            o = obs_tr[t]; e = exp_tr[t]; checks++;
            if (o !== e) begin fails++;
                $display("FAIL pre_reset t=%0d: got vtl=%b per=%0d hi=%0d, expected vtl=%b per=%0d hi=%0d",
                         t, o[34:32], o[31:16], o[15:0], e[34:32], e[31:16], e[15:0]); end
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (cur_tr !== '0) begin fails++;
            $display("FAIL async_reset: got vtl=%b per=%0d hi=%0d, expected all 0",
                     cur_tr[34:32], cur_tr[31:16], cur_tr[15:0]); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wave.delete(); add_phase(0, 3);
        repeat (3) begin add_phase(1, 4); add_phase(0, 6); end
        add_phase(1, 1);
        model_wave(65535); drive_wave();
        foreach (obs_tr[t]) begin
            o = obs_tr[t]; e = exp_tr[t]; checks++;
            if (o !== e) begin fails++;
                $display("FAIL post_reset t=%0d: got vtl=%b per=%0d hi=%0d, expected vtl=%b per=%0d hi=%0d",
                         t, o[34:32], o[31:16], o[15:0], e[34:32], e[31:16], e[15:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_duty();
        test_timeout();
        test_saturation();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_period_meter.md
# clk_period_meter

Fast-domain receiver for divided or slow clock-like signals such as divider-chain outputs. It synchronizes a slow input into `clk`, detects rising edges, and measures period and high time in `clk` cycles. It emits one result per input period with a single-cycle valid strobe. It sits downstream of the clock-divider blocks as their self-check and frequency monitor, and also serves as a general tick-rate meter.

## Interface
- `CNT_W`, 16: width of the period and high-time counters and outputs; minimum 4.
- `clk`  in  1  measurement clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is released synchronously to `clk` upstream.
- `sig_in`  in  1  slow signal to measure; asynchronous to `clk`.
- `period_out`  out  CNT_W  cycles between the last two detected rising edges; reset 0.
- `high_out`  out  CNT_W  cycles `sig_in` was high in that period; reset 0.
- `valid`  out  1  one-cycle strobe when `period_out`/`high_out` update; reset 0.
- `timeout`  out  1  one-cycle strobe when no edge arrives before counter saturation; reset 0.
- `locked`  out  1  high while in MEASURE; reset 0.

## Operation
- Synchronizer: two flops `s1`→`s2`, plus `s2_d` for edge detection. `rise = s2 & ~s2_d`. All flops reset to 0.
- FSM has two states, IDLE and MEASURE. Reset state is IDLE.
- IDLE:
  - Counters are held.
  - On `rise`: set `cnt`=1 and `hcnt`=1, go to MEASURE, `locked`=1.
  - No `valid` is generated; the first edge only arms the block.
- MEASURE, on a cycle without `rise`:
  - `cnt` increments by 1.
  - `hcnt` increments by 1 when `s2`=1, otherwise holds.
- MEASURE, on a cycle with `rise`:
  - Load `period_out`←`cnt` and `high_out`←`hcnt`, and pulse `valid`.
  - Reset `cnt`=1 and `hcnt`=1.
  - Stay in MEASURE.
- Saturation: when `cnt` = 2^CNT_W−1 and there is no `rise`:
  - Pulse `timeout`, go to IDLE, drop `locked`.
  - `period_out`/`high_out` hold their last values.
- Rise in the saturation cycle: `rise` wins. The measurement is reported normally with `period_out`=2^CNT_W−1 and no timeout.
- `hcnt` never exceeds `cnt`, so it cannot saturate independently.
- `valid` and `timeout` are never high in the same cycle.
- `sig_in` held constant: after arming, `timeout` fires every 2^CNT_W−1 cycles of MEASURE. Re-arming then requires a new rise.
- Reset mid-operation: outputs and state return to reset values asynchronously. A measurement in progress is discarded.

## Timing
- `sig_in` rising and setup-met before clk edge k:
  - `s2`=1 after edge k+1.
  - `rise` is true in the cycle after edge k+1.
  - Outputs and `valid` update at edge k+2.
- Input-to-result latency: 2 cycles after the sampling edge. Valid stays high for exactly one cycle.
- `sig_in` running with period P cycles and high time H: steady state gives `period_out`=P and `high_out`=H. The synchronizer may add ±1 cycle of jitter per edge.
- Minimum measurable period: 2 cycles. Input high and low phases must each be ≥1 `clk` period to be seen.
- All outputs are registered; there is no combinational path from `sig_in` to any output.

## Structure
- A shared package `clk_meter_pkg` holds:
  - the state enum: `ST_IDLE`, `ST_MEASURE`;
  - constant `CNT_W_MIN`=4.
- One sub-module, `sync_rise_detect`: 2-flop synchronizer plus edge register, active-low async reset. Outputs `level` (`s2`) and `rise`.
- Top level holds the FSM, the two counters and the output registers. Expected size is about 150–200 lines.

## Test plan
- Reset: hold `rst`=0 with `sig_in` toggling → all outputs 0 and `locked`=0. Release → first rise gives `locked`=1 and no `valid`.
- Steady square wave: `sig_in` toggles every 8 clk cycles (P=16) → from the second rise on, each `valid` shows `period_out`=16 and `high_out`=8, with `valid` spaced 16 cycles apart.
- Duty check: `sig_in` high 3 and low 13 cycles → `period_out`=16, `high_out`=3.
- Timeout: CNT_W=4, one rise then `sig_in` held high:
  - `timeout` pulses exactly once, 15 cycles after arming;
  - `locked`→0;
  - next rise re-arms without `valid`.
- Saturation boundary: CNT_W=4, rises 15 cycles apart → `valid` with `period_out`=15 and no `timeout`. Rises 16 apart → `timeout`, with no `valid` at the late rise.
- Mid-operation reset: assert `rst` 5 cycles into a period → outputs 0 immediately. After release, the first full period reports correctly only after re-arming.
